// File: rtl/vdiv_unit.sv
// Lane-parallel unsigned vector divider: 64-bit word split into 8/4/2/1 lanes,
// one restoring-division step per cycle, 64 cycles per operation for every lane width.
module vdiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [0:63] rA_64bit_val,
  input  logic [0:63] rB_64bit_val,
  input  logic [0:1]  WW,
  input  logic        mod_sel,
  output logic        busy,
  output logic        done,
  output logic [0:63] ALU_out,
  output logic        dz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [63:0] rem_q, rem_d;
  logic [62:0] quo_q, quo_d;
  logic [63:0] out_q, out_d;
  logic [1:0]  ww_q, ww_d;
  logic        mod_q, mod_d;
  logic        dz_q, dz_d;
  logic [2:0]  lane_q, lane_d;
  logic [5:0]  bit_q, bit_d;

  logic [63:0] div_s;
  logic [63:0] b_next_s;
  logic [63:0] rem_sh_s;
  logic [63:0] rem_step_s;
  logic [63:0] quo_step_s;
  logic [63:0] res_s;
  logic [6:0]  slot_sh_s;
  logic        q_bit_s;
  logic        lane_end_s;
  logic        last_lane_s;

  // Lane-width decode: the active divisor always sits in the top w bits of b_q.
  always_comb begin
    div_s       = b_q;
    lane_end_s  = 1'b0;
    last_lane_s = 1'b0;
    slot_sh_s   = 7'd0;
    b_next_s    = 64'd0;
    case (ww_q)
      2'b00: begin
        div_s       = {56'd0, b_q[63:56]};
        lane_end_s  = (bit_q == 6'd7);
        last_lane_s = (lane_q == 3'd7);
        slot_sh_s   = {1'b0, ~lane_q, 3'd0};
        b_next_s    = {b_q[55:0], 8'd0};
      end
      2'b01: begin
        div_s       = {48'd0, b_q[63:48]};
        lane_end_s  = (bit_q == 6'd15);
        last_lane_s = (lane_q[1:0] == 2'd3);
        slot_sh_s   = {1'b0, ~lane_q[1:0], 4'd0};
        b_next_s    = {b_q[47:0], 16'd0};
      end
      2'b10: begin
        div_s       = {32'd0, b_q[63:32]};
        lane_end_s  = (bit_q == 6'd31);
        last_lane_s = (lane_q[0] == 1'b1);
        slot_sh_s   = {1'b0, ~lane_q[0], 5'd0};
        b_next_s    = {b_q[31:0], 32'd0};
      end
      2'b11: begin
        div_s       = b_q;
        lane_end_s  = (bit_q == 6'd63);
        last_lane_s = 1'b1;
        slot_sh_s   = 7'd0;
        b_next_s    = 64'd0;
      end
      default: begin
        div_s       = b_q;
        lane_end_s  = 1'b0;
        last_lane_s = 1'b0;
        slot_sh_s   = 7'd0;
        b_next_s    = 64'd0;
      end
    endcase
  end

  // Restoring step; rem_q[63] set means the shifted value exceeds any 64-bit divisor.
  // A zero divisor naturally yields all-ones quotient and remainder = dividend.
  always_comb begin
    rem_sh_s   = {rem_q[62:0], a_q[63]};
    q_bit_s    = rem_q[63] | (rem_sh_s >= div_s);
    rem_step_s = q_bit_s ? (rem_sh_s - div_s) : rem_sh_s;
    quo_step_s = {quo_q, q_bit_s};
    res_s      = mod_q ? rem_step_s : quo_step_s;
  end

  // Control FSM next state and datapath register updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    out_d   = out_q;
    ww_d    = ww_q;
    mod_d   = mod_q;
    dz_d    = dz_q;
    lane_d  = lane_q;
    bit_d   = bit_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = rA_64bit_val;
          b_d     = rB_64bit_val;
          ww_d    = WW;
          mod_d   = mod_sel;
          rem_d   = 64'd0;
          quo_d   = 63'd0;
          out_d   = 64'd0;
          dz_d    = 1'b0;
          lane_d  = 3'd0;
          bit_d   = 6'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d  = {a_q[62:0], 1'b0};
        dz_d = dz_q | (div_s == 64'd0);
        if (lane_end_s) begin
          out_d   = out_q | (res_s << slot_sh_s);
          rem_d   = 64'd0;
          quo_d   = 63'd0;
          bit_d   = 6'd0;
          lane_d  = lane_q + 3'd1;
          b_d     = b_next_s;
          state_d = last_lane_s ? S_DONE : S_RUN;
        end else begin
          rem_d   = rem_step_s;
          quo_d   = quo_step_s[62:0];
          bit_d   = bit_q + 6'd1;
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= 64'd0;
      b_q     <= 64'd0;
      rem_q   <= 64'd0;
      quo_q   <= 63'd0;
      out_q   <= 64'd0;
      ww_q    <= 2'd0;
      mod_q   <= 1'b0;
      dz_q    <= 1'b0;
      lane_q  <= 3'd0;
      bit_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      out_q   <= out_d;
      ww_q    <= ww_d;
      mod_q   <= mod_d;
      dz_q    <= dz_d;
      lane_q  <= lane_d;
      bit_q   <= bit_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign ALU_out = out_q;
  assign dz      = dz_q;

endmodule

// File: tb/tb_vdiv_unit.sv
// Directed self-checking bench for vdiv_unit with hand-computed expected results.
module tb_vdiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [0:63] rA_64bit_val;
  logic [0:63] rB_64bit_val;
  logic [0:1]  WW;
  logic        mod_sel;
  logic        busy;
  logic        done;
  logic [0:63] ALU_out;
  logic        dz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vdiv_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rA_64bit_val (rA_64bit_val),
    .rB_64bit_val (rB_64bit_val),
    .WW           (WW),
    .mod_sel      (mod_sel),
    .busy         (busy),
    .done         (done),
    .ALU_out      (ALU_out),
    .dz           (dz)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; operands are scrambled right after the start edge.
  task automatic run_op(input string tag, input logic [1:0] ww, input logic md,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input logic exp_dz);
    int lat;
    int bcnt;
    rA_64bit_val = a;
    rB_64bit_val = b;
    WW           = ww;
    mod_sel      = md;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    rA_64bit_val = ~a;
    rB_64bit_val = 64'd0;
    WW           = ~ww;
    mod_sel      = ~md;
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'd64);
    chk({tag, ".busy_cycles"}, 64'(bcnt), 64'd64);
    chk({tag, ".result"}, ALU_out, exp);
    chk({tag, ".dz"}, {63'd0, dz}, {63'd0, exp_dz});
    chk({tag, ".busy_at_done"}, {63'd0, busy}, 64'd0);
    tick();
    chk({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, ".result_hold"}, ALU_out, exp);
  endtask

  initial begin
    int nd;
    reset        = 1'b1;
    start        = 1'b0;
    rA_64bit_val = 64'd0;
    rB_64bit_val = 64'd0;
    WW           = 2'b00;
    mod_sel      = 1'b0;
    #2;
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.done", {63'd0, done}, 64'd0);
    chk("reset.out", ALU_out, 64'd0);
    chk("reset.dz", {63'd0, dz}, 64'd0);
    start = 1'b1;
    tick();
    chk("reset.ignore_start", {63'd0, busy}, 64'd0);
    start = 1'b0;
    reset = 1'b0;

    run_op("vdiv64", 2'b11, 1'b0, 64'd102, 64'd10, 64'd10, 1'b0);
    run_op("vmod64_b2b", 2'b11, 1'b1, 64'd102, 64'd10, 64'd2, 1'b0);
    run_op("vdiv8", 2'b00, 1'b0, 64'hFF00FF00_FF00FF00, 64'h11221122_44444444,
           64'h0F000F00_03000300, 1'b0);
    run_op("vdiv32_dz", 2'b10, 1'b0, 64'h00000064_00000007, 64'h0000000A_00000000,
           64'h0000000A_FFFFFFFF, 1'b1);
    run_op("vmod32_dz", 2'b10, 1'b1, 64'h00000064_00000007, 64'h0000000A_00000000,
           64'h00000000_00000007, 1'b1);
    run_op("vdiv32_small", 2'b10, 1'b0, 64'h00000005_FFFFFFFF, 64'h00000009_00000001,
           64'h00000000_FFFFFFFF, 1'b0);
    run_op("vmod32_small", 2'b10, 1'b1, 64'h00000005_FFFFFFFF, 64'h00000009_00000001,
           64'h00000005_00000000, 1'b0);
    run_op("vmod64_big", 2'b11, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'h80000000_00000000,
           64'h7FFFFFFF_FFFFFFFF, 1'b0);
    run_op("vdiv64_big", 2'b11, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h80000000_00000000,
           64'd1, 1'b0);

    // Start pulses during RUN (cycle 10) and on the finishing edge (cycle 64).
    rA_64bit_val = 64'd100;
    rB_64bit_val = 64'd7;
    WW           = 2'b11;
    mod_sel      = 1'b0;
    start        = 1'b1;
    tick();
    nd = 0;
    for (int i = 1; i <= 64; i++) begin
      if (i == 10 || i == 64) begin
        start        = 1'b1;
        rA_64bit_val = 64'd55;
        rB_64bit_val = 64'd5;
        WW           = 2'b00;
        mod_sel      = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done === 1'b1) nd++;
    end
    start = 1'b0;
    chk("ignore.done_at_64", {63'd0, done}, 64'd1);
    chk("ignore.result", ALU_out, 64'd14);
    chk("ignore.done_count", 64'(nd), 64'd1);
    tick();
    chk("ignore.idle_busy", {63'd0, busy}, 64'd0);
    chk("ignore.idle_done", {63'd0, done}, 64'd0);
    tick();
    chk("ignore.no_restart", {63'd0, busy}, 64'd0);

    // Abort with reset at cycle 30 of a run with a zero-divisor first lane.
    rA_64bit_val = 64'hFF00FF00_FF00FF00;
    rB_64bit_val = 64'h00020304_00000000;
    WW           = 2'b00;
    mod_sel      = 1'b0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 30; i++) tick();
    chk("abort.pre_busy", {63'd0, busy}, 64'd1);
    chk("abort.pre_dz", {63'd0, dz}, 64'd1);
    chk("abort.pre_out", ALU_out, 64'hFF005500_00000000);
    #2;
    reset = 1'b1;
    #1;
    chk("abort.busy", {63'd0, busy}, 64'd0);
    chk("abort.done", {63'd0, done}, 64'd0);
    chk("abort.out", ALU_out, 64'd0);
    chk("abort.dz", {63'd0, dz}, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    chk("abort.no_done", 64'(nd), 64'd0);
    run_op("vmod16_after_reset", 2'b01, 1'b1, 64'h0011_0022_0033_0044,
           64'h0004_0005_0006_0007, 64'h0001_0004_0003_0005, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
